// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared instruction width and instruction field types for the Tomasulo front end
package tomasulo_pkg;

    localparam int INSTR_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_MUL = 4'h3,
        OP_DIV = 4'h4,
        OP_LD  = 4'h5,
        OP_ST  = 4'h6,
        OP_BR  = 4'h7
    } opcode_t;

    typedef struct packed {
        opcode_t    opcode;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

endpackage

// File: rtl/iq_ptr_ctl.sv
// rtl/iq_ptr_ctl.sv - head/tail pointers, occupancy count and accept/clip arithmetic for the instruction queue
module iq_ptr_ctl #(
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = $clog2(DEPTH),
    parameter int ADC_W = $clog2(ENQ_W + 1),
    parameter int RTR_W = $clog2(DEQ_W + 1)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             flush,
    input  logic [ADC_W-1:0] adc,
    input  logic [RTR_W-1:0] rtr,
    output logic [PTR_W-1:0] frente,
    output logic [PTR_W-1:0] tras,
    output logic [CNT_W-1:0] count,
    output logic             enq_ok,
    output logic             cheio,
    output logic             vazio,
    output logic             adcRdy
);

    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] adc_c;
    logic [CNT_W-1:0] rtr_c;
    logic [CNT_W-1:0] enq_eff;
    logic [CNT_W-1:0] deq_eff;

    // Space freed by a same-cycle dequeue is deliberately not counted in free.
    assign free    = CNT_W'(DEPTH) - count;
    assign adc_c   = CNT_W'(adc);
    assign rtr_c   = CNT_W'(rtr);
    assign enq_ok  = (adc_c <= free);
    assign enq_eff = enq_ok ? adc_c : '0;
    assign deq_eff = (rtr_c > count) ? count : rtr_c;

    assign cheio  = (count == CNT_W'(DEPTH));
    assign vazio  = (count == '0);
    assign adcRdy = (free >= CNT_W'(ENQ_W));

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            frente <= '0;
            tras   <= '0;
            count  <= '0;
        end else if (flush) begin
            frente <= '0;
            tras   <= '0;
            count  <= '0;
        end else begin
            frente <= frente + PTR_W'(deq_eff);
            tras   <= tras + PTR_W'(enq_eff);
            count  <= count + enq_eff - deq_eff;
        end
    end

endmodule

// File: rtl/instr_queue_mw.sv
// rtl/instr_queue_mw.sv - multi-wide in-order instruction queue between fetch and dispatch
module instr_queue_mw
    import tomasulo_pkg::*;
#(
    parameter int WIDTH = INSTR_WIDTH,
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       flush,
    input  logic [$clog2(ENQ_W+1)-1:0] adc,
    input  logic [ENQ_W*WIDTH-1:0]     instrIn,
    input  logic [$clog2(DEQ_W+1)-1:0] rtr,
    output logic [DEQ_W*WIDTH-1:0]     instrOut,
    output logic [DEQ_W-1:0]           outValid,
    output logic [CNT_W-1:0]           count,
    output logic                       cheio,
    output logic                       vazio,
    output logic                       adcRdy
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] frente;
    logic [PTR_W-1:0] tras;
    logic             enq_ok;

    iq_ptr_ctl #(
        .DEPTH (DEPTH),
        .ENQ_W (ENQ_W),
        .DEQ_W (DEQ_W),
        .CNT_W (CNT_W)
    ) u_ptr (
        .CLK    (CLK),
        .CLR    (CLR),
        .flush  (flush),
        .adc    (adc),
        .rtr    (rtr),
        .frente (frente),
        .tras   (tras),
        .count  (count),
        .enq_ok (enq_ok),
        .cheio  (cheio),
        .vazio  (vazio),
        .adcRdy (adcRdy)
    );

    // Storage has no reset: validity is tracked solely by the pointer/count logic.
    always_ff @(posedge CLK) begin
        if (!flush && enq_ok) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (i < int'(adc))
                    mem[tras + PTR_W'(i)] <= instrIn[i*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar g = 0; g < DEQ_W; g++) begin : g_head
        assign instrOut[g*WIDTH +: WIDTH] = mem[frente + PTR_W'(g)];
        assign outValid[g]                = (CNT_W'(g) < count);
    end

endmodule

// File: tb/tb_instr_queue_mw.sv
// tb/tb_instr_queue_mw.sv - scoreboard bench for instr_queue_mw with directed and seeded vectors
module tb_instr_queue_mw;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  adc = '0;
    logic [31:0] instrIn = '0;
    logic [1:0]  rtr = '0;
    logic [31:0] instrOut;
    logic [1:0]  outValid;
    logic [3:0]  count;
    logic        cheio, vazio, adcRdy;

    instr_queue_mw dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .flush    (flush),
        .adc      (adc),
        .instrIn  (instrIn),
        .rtr      (rtr),
        .instrOut (instrOut),
        .outValid (outValid),
        .count    (count),
        .cheio    (cheio),
        .vazio    (vazio),
        .adcRdy   (adcRdy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cnt;
        logic [1:0]  val;
        logic [15:0] s0;
        logic [15:0] s1;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mq[$];
    int          passed = 0;
    int          total = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int flags_for(input int c);
        return {c == 8, c == 0, (8 - c) >= 2};
    endfunction

    exp_t mon_e;
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("count", int'(count), mon_e.cnt);
            chk("outValid", int'(outValid), int'(mon_e.val));
            chk("flags{cheio,vazio,adcRdy}", int'({cheio, vazio, adcRdy}), flags_for(mon_e.cnt));
            if (mon_e.val[0]) chk("slot0", int'(instrOut[15:0]), int'(mon_e.s0));
            if (mon_e.val[1]) chk("slot1", int'(instrOut[31:16]), int'(mon_e.s1));
        end
    end

    // hand < 0 means take the expected count from the reference queue.
    task automatic step(input int a, input logic [15:0] d0, input logic [15:0] d1,
                        input int r, input logic f, input int hand);
        exp_t e;
        int   n;
        int   deq;
        adc     = a[1:0];
        instrIn = {d1, d0};
        rtr     = r[1:0];
        flush   = f;
        n = mq.size();
        if (f) begin
            mq.delete();
        end else begin
            deq = (r < n) ? r : n;
            repeat (deq) void'(mq.pop_front());
            if (a <= 8 - n) begin
                if (a > 0) mq.push_back(d0);
                if (a > 1) mq.push_back(d1);
            end
        end
        e.cnt = (hand >= 0) ? hand : mq.size();
        e.val = (e.cnt >= 2) ? 2'b11 : (e.cnt == 1) ? 2'b01 : 2'b00;
        e.s0  = (mq.size() > 0) ? mq[0] : 16'h0;
        e.s1  = (mq.size() > 1) ? mq[1] : 16'h0;
        @(posedge CLK);
        sb.push_back(e);
        #1;
        adc   = '0;
        rtr   = '0;
        flush = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_vazio"}, int'(vazio), 1);
        chk({tag, "_cheio"}, int'(cheio), 0);
        chk({tag, "_adcRdy"}, int'(adcRdy), 1);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_outValid"}, int'(outValid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] k;
        #2 CLR = 1'b1;
        #1 check_reset_state("reset");
        @(posedge CLK);
        #1 CLR = 1'b0;

        // fill with pairs
        step(2, 16'h0001, 16'h0002, 0, 0, 2);
        step(2, 16'h0003, 16'h0004, 0, 0, 4);
        step(2, 16'h0005, 16'h0006, 0, 0, 6);
        step(2, 16'h0007, 16'h0008, 0, 0, 8);

        // overflow: group of two dropped at count 7, single accepted
        step(0, 16'h0000, 16'h0000, 1, 0, 7);
        step(2, 16'hAAAA, 16'hBBBB, 0, 0, 7);
        step(1, 16'hAAAA, 16'hBBBB, 0, 0, 8);

        // drain including clipped over-request on empty
        step(0, 16'h0000, 16'h0000, 2, 0, 6);
        step(0, 16'h0000, 16'h0000, 2, 0, 4);
        step(0, 16'h0000, 16'h0000, 2, 0, 2);
        step(0, 16'h0000, 16'h0000, 2, 0, 0);
        step(0, 16'h0000, 16'h0000, 2, 0, 0);

        // simultaneous enqueue/dequeue
        step(1, 16'h0101, 16'h0000, 0, 0, 1);
        step(2, 16'h0201, 16'h0202, 2, 0, 2);
        step(2, 16'h0301, 16'h0302, 0, 0, 4);
        step(2, 16'h0401, 16'h0402, 0, 0, 6);
        step(1, 16'h0501, 16'h0000, 0, 0, 7);
        step(2, 16'hDEAD, 16'hBEEF, 1, 0, 6);

        // seeded mixed traffic against the reference queue
        k = 16'h3000;
        for (int i = 0; i < 20; i++) begin
            step($urandom_range(0, 2), k, k + 16'h1, $urandom_range(0, 2), 0, -1);
            k = k + 16'h2;
        end

        // flush beats same-cycle enqueue and dequeue
        step(0, 16'h0000, 16'h0000, 0, 1, 0);
        step(2, 16'h0601, 16'h0602, 0, 0, 2);
        step(2, 16'h0603, 16'h0604, 0, 0, 4);
        step(1, 16'h0605, 16'h0000, 0, 0, 5);
        step(2, 16'h0701, 16'h0702, 1, 1, 0);
        step(1, 16'h1234, 16'h0000, 0, 0, 1);

        // asynchronous clear between edges
        step(2, 16'h0801, 16'h0802, 0, 0, 3);
        @(negedge CLK);
        #2 CLR = 1'b1;
        #1 check_reset_state("midclr");
        mq.delete();
        @(posedge CLK);
        #1 CLR = 1'b0;
        step(1, 16'h5555, 16'h0000, 0, 0, 1);
        step(0, 16'h0000, 16'h0000, 1, 0, 0);

        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_queue_mw.md
# instr_queue_mw

Parametrised multi-wide instruction queue for the Tomasulo front end: accepts up to ENQ_W instructions per cycle from fetch and presents up to DEQ_W oldest instructions per cycle to dispatch, in strict program order. It replaces the single-wide 8x16 queue with generic width and depth, an exact occupancy count, a first-word-fall-through head window, and a flush for branch mispredicts. It sits between fetch and the reservation-station dispatch logic.

## Interface
- WIDTH, 16, instruction width in bits
- DEPTH, 8, number of entries; a power of two, at least 4
- ENQ_W, 2, maximum instructions enqueued per cycle; at most DEPTH
- DEQ_W, 2, maximum instructions dequeued per cycle; at most DEPTH
- CNT_W, $clog2(DEPTH+1), width of the occupancy count
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- flush  in  1  discard all entries (mispredict)
- adc  in  $clog2(ENQ_W+1)  number of valid instructions on instrIn this cycle
- instrIn  in  ENQ_W*WIDTH  slot 0 in bits [WIDTH-1:0] is the oldest
- rtr  in  $clog2(DEQ_W+1)  number of instructions dispatch consumes this cycle
- instrOut  out  DEQ_W*WIDTH  oldest DEQ_W entries; slot 0 holds the head
- outValid  out  DEQ_W  per-slot valid; thermometer-coded from bit 0
- count  out  CNT_W  number of occupied entries, 0..DEPTH
- cheio  out  1  full: count == DEPTH
- vazio  out  1  empty: count == 0
- adcRdy  out  1  free space is at least ENQ_W

## Operation
- Circular buffer with head pointer `frente`, tail pointer `tras` and an explicit count register. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Full and empty are derived from count only, never from pointer equality.
- Enqueue is all-or-nothing. If `adc > DEPTH - count` (evaluated on the pre-edge count), the whole group is dropped and no state changes. Otherwise slots `0..adc-1` are written to `tras..tras+adc-1` and `tras` advances by `adc`.
- Dequeue: the effective amount is `min(rtr, count)` on the pre-edge count. `frente` advances by that amount. A request beyond the available entries is clipped, with no error.
- No bypass: entries written this cycle are not visible on instrOut until the next cycle, and space freed by a same-cycle dequeue is not available to enqueue until the next cycle.
- Same-edge update: `count_next = count + enq_accepted - deq_effective`.
- Head window (combinational from storage): `instrOut` slot i = entry `frente+i`, and `outValid[i] = (i < count)`. Invalid slots carry don't-care data.
- Flush has priority over enqueue and dequeue in the same cycle. It zeroes `frente`, `tras` and count. Storage contents are left as is.

## Timing
- CLR asynchronous: `frente`, `tras` and count go to 0 immediately. Resulting outputs: vazio=1, cheio=0, adcRdy=1, outValid=0, count=0. instrOut is don't-care.
- CLR released mid-operation loses all contents. The first enqueue after release is accepted on the first rising edge with CLR low.
- Enqueue-to-visible latency is 1 cycle. An instruction is on instrOut slot 0 the cycle after it is accepted into an empty queue.
- Dequeue takes effect at the edge. The next head appears the same cycle after that edge.
- All outputs are functions of registers only. The combinational path from instrIn/adc/rtr to outputs is zero.

## Structure
- Shared package `tomasulo_pkg`: WIDTH default constant and instruction field/opcode typedefs (shared with the reservation stations).
- Sub-module `iq_ptr_ctl` holds the pointers, count, clip/accept arithmetic and flags. Storage and read muxing stay in the top module.

## Test plan
- Reset then idle: CLR pulse mid-cycle gives immediate vazio=1, count=0, adcRdy=1, outValid=2'b00.
- Fill: DEPTH=8, enqueue pairs 0x0001..0x0008 over 4 cycles. Expect count=8, cheio=1, adcRdy=0, instrOut={0x0002,0x0001}, outValid=2'b11.
- Overflow: at count=7, adc=2 with 0xAAAA/0xBBBB gives the group dropped and count stays 7. The same cycle with adc=1 gives count=8.
- Wrap-around and order: run 20 cycles of random adc/rtr in 0..2 against a reference model. Dequeued sequence equals enqueued sequence exactly, and pointers wrap past index 7.
- Simultaneous events: at count=1, adc=2 and rtr=2 dequeue 1 and enqueue 2, giving count=2. At count=7, adc=2 and rtr=1 drop the enqueue, giving count=6.
- Flush: at count=5 with adc=2 and rtr=1, flush=1 gives count=0 and vazio=1 next cycle. A subsequent enqueue of 0x1234 appears on slot 0.
